climate_trend_monitor: RTL and testbench

Downstream consumer of the climate prediction stage. Captures each climate_condition code qualified by the predictor's done pulse, buffers valid codes in a FIFO for a valid/ready reader, and runs a storm-persistence FSM. Raises storm_alert after ALERT_RUN consecutive STORM predictions. Also keeps saturating diagnostic counters for dropped and malformed samples.

---
 rtl/climate_trend_monitor.sv | 187 ++++++++++++++++++
 tb/tb_climate_trend_monitor.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/climate_trend_monitor.sv
// Climate trend monitor: captures predictor results on done rising edges, buffers legal codes
// for a valid/ready reader, tracks STORM persistence and counts dropped/malformed samples.
module climate_trend_monitor #(
    parameter int DEPTH     = 8,
    parameter int ALERT_RUN = 3,
    parameter int CNT_W     = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [2:0]              climate_condition,
    input  logic                    done,
    input  logic                    out_ready,
    output logic                    out_valid,
    output logic [2:0]              out_code,
    output logic [$clog2(DEPTH):0]  fifo_count,
    output logic                    storm_alert,
    output logic [7:0]              storm_run,
    output logic [CNT_W-1:0]        overflow_cnt,
    output logic [CNT_W-1:0]        bad_code_cnt
);

    // state | meaning
    // CALM  | no STORM run in progress
    // WATCH | STORM run started, shorter than ALERT_RUN
    // ALERT | STORM run of at least ALERT_RUN, storm_alert high
    typedef enum logic [1:0] {
        CALM  = 2'd0,
        WATCH = 2'd1,
        ALERT = 2'd2
    } state_t;

    localparam int               AW       = $clog2(DEPTH);
    localparam logic [AW:0]      FULL_CNT = (AW + 1)'(DEPTH);
    localparam logic [7:0]       RUN_TGT  = 8'(ALERT_RUN);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [2:0]       CODE_STORM = 3'd3;

    logic           done_q;
    logic           armed;
    logic           capture;
    logic           legal;
    logic           is_storm;
    logic           push_req;
    logic           push;
    logic           pop;
    logic           full;
    logic           drop;
    logic           bad;

    logic [2:0]     mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [AW:0]    count;

    state_t         state_q;
    state_t         state_d;
    logic [7:0]     run_q;
    logic [7:0]     run_d;
    logic [7:0]     run_inc;

    // armed blocks a done that is already high when reset releases; it needs a low first
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_q <= 1'b0;
            armed  <= 1'b0;
        end else begin
            done_q <= done;
            armed  <= armed | ~done;
        end
    end

    assign capture  = done & ~done_q & armed;
    assign legal    = (climate_condition != 3'd0) && (climate_condition <= 3'd4);
    assign is_storm = (climate_condition == CODE_STORM);
    assign push_req = capture & legal;
    assign bad      = capture & ~legal;

    assign full     = (count == FULL_CNT);
    assign out_valid = (count != '0);
    assign pop      = out_valid & out_ready;
    assign push     = push_req & (~full | pop);
    assign drop     = push_req & full & ~pop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= 3'd0;
            end
        end else if (push) begin
            mem[wr_ptr] <= climate_condition;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign out_code   = mem[rd_ptr];
    assign fifo_count = count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_cnt <= '0;
            bad_code_cnt <= '0;
        end else begin
            if (drop && overflow_cnt != CNT_MAX) begin
                overflow_cnt <= overflow_cnt + 1'b1;
            end
            if (bad && bad_code_cnt != CNT_MAX) begin
                bad_code_cnt <= bad_code_cnt + 1'b1;
            end
        end
    end

    // dropped samples still feed the FSM, so it keys off push_req rather than push
    assign run_inc = run_q + 8'd1;

    always_comb begin
        state_d = state_q;
        run_d   = run_q;
        if (push_req) begin
            case (state_q)
                CALM: begin
                    if (is_storm) begin
                        run_d   = 8'd1;
                        state_d = (RUN_TGT == 8'd1) ? ALERT : WATCH;
                    end else begin
                        run_d = 8'd0;
                    end
                end
                WATCH: begin
                    if (is_storm) begin
                        run_d = run_inc;
                        if (run_inc == RUN_TGT) begin
                            state_d = ALERT;
                        end
                    end else begin
                        run_d   = 8'd0;
                        state_d = CALM;
                    end
                end
                ALERT: begin
                    if (is_storm) begin
                        run_d = (run_q == 8'hFF) ? run_q : run_inc;
                    end else begin
                        run_d   = 8'd0;
                        state_d = CALM;
                    end
                end
                default: begin
                    run_d   = 8'd0;
                    state_d = CALM;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= CALM;
            run_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            run_q   <= run_d;
        end
    end

    assign storm_alert = (state_q == ALERT);
    assign storm_run   = run_q;

endmodule

// File: tb/tb_climate_trend_monitor.sv
// Directed bench for climate_trend_monitor: inputs driven and outputs sampled on the falling edge.
module tb_climate_trend_monitor;

    logic        clk;
    logic        rst_n;
    logic [2:0]  climate_condition;
    logic        done;
    logic        out_ready;
    logic        out_valid;
    logic [2:0]  out_code;
    logic [3:0]  fifo_count;
    logic        storm_alert;
    logic [7:0]  storm_run;
    logic [7:0]  overflow_cnt;
    logic [7:0]  bad_code_cnt;

    int n_chk  = 0;
    int n_pass = 0;

    climate_trend_monitor #(
        .DEPTH(8),
        .ALERT_RUN(3),
        .CNT_W(8)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .climate_condition(climate_condition),
        .done(done),
        .out_ready(out_ready),
        .out_valid(out_valid),
        .out_code(out_code),
        .fifo_count(fifo_count),
        .storm_alert(storm_alert),
        .storm_run(storm_run),
        .overflow_cnt(overflow_cnt),
        .bad_code_cnt(bad_code_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        done = 1'b0;
        out_ready = 1'b0;
        climate_condition = 3'd0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // one-cycle done pulse; returns on the falling edge right after the capture edge
    task automatic pulse(input logic [2:0] code);
        climate_condition = code;
        done = 1'b1;
        @(negedge clk);
        done = 1'b0;
    endtask

    task automatic gap();
        @(negedge clk);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_valid"}, out_valid, 0);
        chk({tag, "_code"}, out_code, 0);
        chk({tag, "_count"}, fifo_count, 0);
        chk({tag, "_alert"}, storm_alert, 0);
        chk({tag, "_run"}, storm_run, 0);
        chk({tag, "_ovf"}, overflow_cnt, 0);
        chk({tag, "_bad"}, bad_code_cnt, 0);
    endtask

    logic [2:0] fill_codes [10] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd4, 3'd3, 3'd2, 3'd1, 3'd2, 3'd3};
    logic [2:0] drain_codes [8] = '{3'd2, 3'd3, 3'd4, 3'd4, 3'd3, 3'd2, 3'd1, 3'd4};

    initial begin
        rst_n = 1'b0;
        done = 1'b0;
        out_ready = 1'b0;
        climate_condition = 3'd0;

        do_reset();
        chk_all_zero("rst");

        // SNOW, SUNNY, STORM streamed straight through
        out_ready = 1'b1;
        pulse(3'd1);
        chk("t1_v1", out_valid, 1);
        chk("t1_c1", out_code, 1);
        chk("t1_n1", fifo_count, 1);
        gap();
        chk("t1_drain1", fifo_count, 0);
        pulse(3'd2);
        chk("t1_c2", out_code, 2);
        chk("t1_n2", fifo_count, 1);
        gap();
        pulse(3'd3);
        chk("t1_c3", out_code, 3);
        chk("t1_n3", fifo_count, 1);
        chk("t1_run", storm_run, 1);
        chk("t1_alert", storm_alert, 0);
        gap();
        chk("t1_empty", out_valid, 0);

        // alert rise and fall
        do_reset();
        out_ready = 1'b1;
        pulse(3'd3);
        chk("t2_run1", storm_run, 1);
        chk("t2_al1", storm_alert, 0);
        gap();
        pulse(3'd3);
        chk("t2_run2", storm_run, 2);
        chk("t2_al2", storm_alert, 0);
        gap();
        pulse(3'd3);
        chk("t2_run3", storm_run, 3);
        chk("t2_al3", storm_alert, 1);
        gap();
        pulse(3'd2);
        chk("t2_run0", storm_run, 0);
        chk("t2_al0", storm_alert, 0);
        gap();

        // fill past full, then push+pop at full, then drain in order
        do_reset();
        for (int i = 0; i < 10; i++) begin
            pulse(fill_codes[i]);
            gap();
        end
        chk("t3_count", fifo_count, 8);
        chk("t3_ovf", overflow_cnt, 2);
        chk("t3_head", out_code, 1);
        out_ready = 1'b1;
        pulse(3'd4);
        chk("t3_pp_count", fifo_count, 8);
        chk("t3_pp_ovf", overflow_cnt, 2);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("t3_rd%0d", i), out_code, drain_codes[i]);
            gap();
        end
        chk("t3_drained", fifo_count, 0);
        chk("t3_drained_v", out_valid, 0);

        // malformed codes interleaved with a STORM run
        do_reset();
        out_ready = 1'b1;
        pulse(3'd3);
        gap();
        pulse(3'd0);
        chk("t4_bad0_n", fifo_count, 0);
        gap();
        pulse(3'd3);
        gap();
        pulse(3'd5);
        chk("t4_bad5_v", out_valid, 0);
        chk("t4_bad5_run", storm_run, 2);
        gap();
        pulse(3'd3);
        gap();
        pulse(3'd7);
        chk("t4_bad", bad_code_cnt, 3);
        chk("t4_run", storm_run, 3);
        chk("t4_alert", storm_alert, 1);
        chk("t4_n", fifo_count, 0);
        gap();

        // done held high: one capture only
        do_reset();
        climate_condition = 3'd3;
        done = 1'b1;
        repeat (5) @(negedge clk);
        done = 1'b0;
        chk("t5_count", fifo_count, 1);
        chk("t5_run", storm_run, 1);
        chk("t5_head", out_code, 3);

        // async reset mid-stream, done high across release
        do_reset();
        pulse(3'd1);
        gap();
        pulse(3'd3);
        gap();
        pulse(3'd3);
        gap();
        pulse(3'd3);
        gap();
        pulse(3'd6);
        gap();
        chk("t6_count", fifo_count, 4);
        chk("t6_alert", storm_alert, 1);
        chk("t6_bad", bad_code_cnt, 1);
        climate_condition = 3'd3;
        done = 1'b1;
        #2 rst_n = 1'b0;
        #1 chk_all_zero("t6_async");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("t6_nocap_n", fifo_count, 0);
        chk("t6_nocap_run", storm_run, 0);
        done = 1'b0;
        @(negedge clk);
        done = 1'b1;
        @(negedge clk);
        done = 1'b0;
        chk("t6_cap_n", fifo_count, 1);
        chk("t6_cap_run", storm_run, 1);
        chk("t6_cap_code", out_code, 3);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
